dataflow_channel_monitor: RTL

//   Parametrised multi-channel dataflow monitor for simulation benches and on-chip debug. Observes NUM_CH

---
 rtl/dataflow_channel_monitor.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dataflow_channel_monitor.sv
// dataflow_channel_monitor
//   Watches NUM_CH valid/ready channels. For each channel it counts transfers,
//   stall cycles and starve cycles. It also counts the cycles spent in RUN and
//   flags a hang when no channel has moved for DEADLOCK_CYCLES cycles while a
//   valid is still pending. Counters are read back one at a time through a
//   registered read port.
//
//   Handshake: on channel i, a transfer happens on every clock edge where
//   ch_valid[i] && ch_ready[i] is true. A stall is valid && !ready. A starve is
//   !valid && ready. The monitor only observes these signals and never drives
//   them.
//
//   Optional build macro DATAFLOW_MONITOR_STALL_RUN_EN adds, for each channel,
//   a counter of the current stall run and a register holding the longest run
//   seen. The longest run is readable at rd_sel=3.
module dataflow_channel_monitor #(
  parameter int NUM_CH          = 4,
  parameter int CNT_W           = 32,
  parameter int DEADLOCK_CYCLES = 1024,
  localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  cycles,
  output logic              deadlock
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_HANG = 2'd3
  } state_t;

  // The threshold is held one bit wider than the counter, so a saturated idle
  // counter still compares correctly against it.
  localparam logic [CNT_W:0] DL_THRESH = (CNT_W+1)'(DEADLOCK_CYCLES);

  state_t           cur_state, nxt_state;
  logic             clr_all, set_dead, counting, any_xfer, hang_hit;
  logic [CNT_W-1:0] idle_cnt, idle_nxt, rd_mux;
  logic [CNT_W-1:0] xfer_cnt   [NUM_CH];
  logic [CNT_W-1:0] stall_cnt  [NUM_CH];
  logic [CNT_W-1:0] starve_cnt [NUM_CH];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign state    = cur_state;
  assign counting = (cur_state == S_RUN);
  assign any_xfer = |(ch_valid & ch_ready);
  assign idle_nxt = any_xfer ? '0 : sat_inc(idle_cnt);
  assign hang_hit = (DEADLOCK_CYCLES != 0) && ({1'b0, idle_nxt} >= DL_THRESH) && (|ch_valid);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_state <= S_IDLE;
    else        cur_state <= nxt_state;
  end

  // Next state, plus the clear and deadlock-set strobes for the counter bank
  always_comb begin
    nxt_state = cur_state;
    clr_all   = 1'b0;
    set_dead  = 1'b0;
    case (cur_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          nxt_state = S_RUN;
          clr_all   = 1'b1;
        end else if (clear) begin
          clr_all   = 1'b1;
        end
      end
      S_RUN: begin
        if (finish) begin
          nxt_state = S_DONE;
        end else if (hang_hit) begin
          nxt_state = S_HANG;
          set_dead  = 1'b1;
        end
      end
      S_HANG: begin
        if (clear)  clr_all   = 1'b1;
        if (finish) nxt_state = S_DONE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Event counters: cleared on start/clear, updated only in RUN, saturating
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles   <= '0;
      idle_cnt <= '0;
      deadlock <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        xfer_cnt[i]   <= '0;
        stall_cnt[i]  <= '0;
        starve_cnt[i] <= '0;
      end
    end else if (clr_all) begin
      cycles   <= '0;
      idle_cnt <= '0;
      deadlock <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        xfer_cnt[i]   <= '0;
        stall_cnt[i]  <= '0;
        starve_cnt[i] <= '0;
      end
    end else if (counting) begin
      cycles   <= sat_inc(cycles);
      idle_cnt <= idle_nxt;
      if (set_dead) deadlock <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid[i] && ch_ready[i])  xfer_cnt[i]   <= sat_inc(xfer_cnt[i]);
        else if (ch_valid[i])            stall_cnt[i]  <= sat_inc(stall_cnt[i]);
        else if (ch_ready[i])            starve_cnt[i] <= sat_inc(starve_cnt[i]);
      end
    end
  end

`ifdef DATAFLOW_MONITOR_STALL_RUN_EN
  logic [CNT_W-1:0] run_cnt [NUM_CH];
  logic [CNT_W-1:0] run_nxt [NUM_CH];
  logic [CNT_W-1:0] max_run [NUM_CH];

  // The current stall run grows while the channel stalls and drops to zero otherwise
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      run_nxt[i] = (ch_valid[i] && !ch_ready[i]) ? sat_inc(run_cnt[i]) : '0;
  end

  // The longest run tracks the post-update run, so a run ending on finish still counts
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run_cnt[i] <= '0;
        max_run[i] <= '0;
      end
    end else if (clr_all) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run_cnt[i] <= '0;
        max_run[i] <= '0;
      end
    end else if (counting) begin
      for (int i = 0; i < NUM_CH; i++) begin
        run_cnt[i] <= run_nxt[i];
        if (run_nxt[i] > max_run[i]) max_run[i] <= run_nxt[i];
      end
    end
  end
`endif

  // Read mux: out-of-range channels read as zero
  always_comb begin
    rd_mux = '0;
    if (int'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        2'd0: rd_mux = xfer_cnt[rd_ch];
        2'd1: rd_mux = stall_cnt[rd_ch];
        2'd2: rd_mux = starve_cnt[rd_ch];
`ifdef DATAFLOW_MONITOR_STALL_RUN_EN
        2'd3: rd_mux = max_run[rd_ch];
`else
        2'd3: rd_mux = '0;
`endif
        default: rd_mux = '0;
      endcase
    end
  end

  // Registered read port: captures the counter value as it stands in the rd_en cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_data <= rd_mux;
    end
  end

endmodule
